// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: shifts digits into a 4-digit HH:MM buffer, validates it on a
// button press and issues a one-cycle load strobe to the alarm register or time counter.
module key_entry_ctrl #(
    parameter logic [3:0] NOKEY   = 4'd10,
    parameter int         TIMEOUT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic       one_second,
    output logic [3:0] key_buffer_ms_hr,
    output logic [3:0] key_buffer_ls_hr,
    output logic [3:0] key_buffer_ms_min,
    output logic [3:0] key_buffer_ls_min,
    output logic       load_alarm,
    output logic       load_new_time,
    output logic       show_alarm,
    output logic       show_new_time,
    output logic       entry_error
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SHOW_ALARM = 3'd1;
    localparam logic [2:0] KEY_STORED = 3'd2;
    localparam logic [2:0] KEY_WAIT   = 3'd3;
    localparam logic [2:0] KEY_ENTRY  = 3'd4;
    localparam logic [2:0] COMMIT     = 3'd5;

    localparam logic [4:0] TIMEOUT_CNT = 5'(TIMEOUT);

    logic [2:0] state;
    logic [3:0] digit;
    logic [3:0] key_prev;
    logic [2:0] digit_count;
    logic [4:0] tick_count;
    logic       commit_alarm;

    logic key_is_digit;
    logic new_press;
    logic timeout_hit;
    logic hours_ok;
    logic entry_valid;
    logic clear_entry;

    assign key_is_digit = (key <= 4'd9);
    assign new_press    = key_is_digit && (key_prev == NOKEY);
    assign timeout_hit  = one_second && ((tick_count + 5'd1) == TIMEOUT_CNT);

    assign hours_ok    = (key_buffer_ms_hr <= 4'd1) ||
                         ((key_buffer_ms_hr == 4'd2) && (key_buffer_ls_hr <= 4'd3));
    assign entry_valid = (digit_count == 3'd4) && hours_ok &&
                         (key_buffer_ms_min <= 4'd5) && (key_buffer_ls_min <= 4'd9);

    // A press or a button in KEY_ENTRY outranks the final timeout tick.
    assign clear_entry = (state == COMMIT) ||
                         ((state == KEY_WAIT) && timeout_hit) ||
                         ((state == KEY_ENTRY) && !new_press && !alarm_button &&
                          !time_button && timeout_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            digit             <= 4'd0;
            key_prev          <= NOKEY;
            digit_count       <= 3'd0;
            tick_count        <= 5'd0;
            commit_alarm      <= 1'b0;
            key_buffer_ms_hr  <= 4'd0;
            key_buffer_ls_hr  <= 4'd0;
            key_buffer_ms_min <= 4'd0;
            key_buffer_ls_min <= 4'd0;
        end else begin
            key_prev <= key_is_digit ? key : NOKEY;

            case (state)
                IDLE: begin
                    if (new_press) begin
                        digit <= key;
                        state <= KEY_STORED;
                    end else if (alarm_button) begin
                        state <= SHOW_ALARM;
                    end
                end
                SHOW_ALARM: begin
                    if (!alarm_button) state <= IDLE;
                end
                KEY_STORED: begin
                    key_buffer_ms_hr  <= key_buffer_ls_hr;
                    key_buffer_ls_hr  <= key_buffer_ms_min;
                    key_buffer_ms_min <= key_buffer_ls_min;
                    key_buffer_ls_min <= digit;
                    if (digit_count != 3'd4) digit_count <= digit_count + 3'd1;
                    tick_count <= 5'd0;
                    state      <= KEY_WAIT;
                end
                KEY_WAIT: begin
                    if (one_second) tick_count <= tick_count + 5'd1;
                    if (!key_is_digit) state <= KEY_ENTRY;
                end
                KEY_ENTRY: begin
                    if (new_press) begin
                        digit      <= key;
                        tick_count <= 5'd0;
                        state      <= KEY_STORED;
                    end else if (alarm_button) begin
                        commit_alarm <= 1'b1;
                        state        <= COMMIT;
                    end else if (time_button) begin
                        commit_alarm <= 1'b0;
                        state        <= COMMIT;
                    end else if (one_second) begin
                        tick_count <= tick_count + 5'd1;
                    end
                end
                COMMIT: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Commit completion and timeout both abandon the entry the same way.
            if (clear_entry) begin
                state             <= IDLE;
                digit_count       <= 3'd0;
                tick_count        <= 5'd0;
                key_buffer_ms_hr  <= 4'd0;
                key_buffer_ls_hr  <= 4'd0;
                key_buffer_ms_min <= 4'd0;
                key_buffer_ls_min <= 4'd0;
            end
        end
    end

    assign load_alarm    = (state == COMMIT) && commit_alarm && entry_valid;
    assign load_new_time = (state == COMMIT) && !commit_alarm && entry_valid;
    assign entry_error   = (state == COMMIT) && !entry_valid;
    assign show_alarm    = (state == SHOW_ALARM);
    assign show_new_time = (state == KEY_STORED) || (state == KEY_WAIT) ||
                           (state == KEY_ENTRY) || (state == COMMIT);

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Table-driven bench for key_entry_ctrl: each record is one clock of inputs plus the
// outputs expected just after that edge; timeout and held-key cases are hand sequences.
module tb_key_entry_ctrl;

    localparam logic [3:0] NK = 4'd10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       one_second;
    logic [3:0] key_buffer_ms_hr;
    logic [3:0] key_buffer_ls_hr;
    logic [3:0] key_buffer_ms_min;
    logic [3:0] key_buffer_ls_min;
    logic       load_alarm;
    logic       load_new_time;
    logic       show_alarm;
    logic       show_new_time;
    logic       entry_error;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_entry_ctrl #(.NOKEY(4'd10), .TIMEOUT(10)) dut (
        .clk               (clk),
        .reset             (reset),
        .key               (key),
        .alarm_button      (alarm_button),
        .time_button       (time_button),
        .one_second        (one_second),
        .key_buffer_ms_hr  (key_buffer_ms_hr),
        .key_buffer_ls_hr  (key_buffer_ls_hr),
        .key_buffer_ms_min (key_buffer_ms_min),
        .key_buffer_ls_min (key_buffer_ls_min),
        .load_alarm        (load_alarm),
        .load_new_time     (load_new_time),
        .show_alarm        (show_alarm),
        .show_new_time     (show_new_time),
        .entry_error       (entry_error)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  key;
        logic        abtn;
        logic        tbtn;
        logic        tick;
        logic [15:0] exp_buf;
        logic        la;
        logic        lt;
        logic        sa;
        logic        snt;
        logic        err;
    } vec_t;

    vec_t table_q[$];

    task automatic add(input string name, input logic r, input logic [3:0] k,
                       input logic a, input logic t, input logic o, input logic [15:0] b,
                       input logic la, input logic lt, input logic sa, input logic snt,
                       input logic err);
        vec_t v;
        v.name = name; v.rst = r; v.key = k; v.abtn = a; v.tbtn = t; v.tick = o;
        v.exp_buf = b; v.la = la; v.lt = lt; v.sa = sa; v.snt = snt; v.err = err;
        table_q.push_back(v);
    endtask

    // One keystroke: press for a cycle, then two NOKEY cycles to reach KEY_ENTRY.
    task automatic add_digit(input string name, input logic [3:0] d,
                             input logic [15:0] b0, input logic [15:0] b1);
        add(name, 1'b1, d,  1'b0, 1'b0, 1'b0, b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(name, 1'b1, NK, 1'b0, 1'b0, 1'b0, b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(name, 1'b1, NK, 1'b0, 1'b0, 1'b0, b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic add_idle(input string name);
        add(name, 1'b1, NK, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply(input vec_t v);
        logic [20:0] got;
        logic [20:0] want;
        reset        = v.rst;
        key          = v.key;
        alarm_button = v.abtn;
        time_button  = v.tbtn;
        one_second   = v.tick;
        @(posedge clk);
        #1;
        got  = {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min,
                load_alarm, load_new_time, show_alarm, show_new_time, entry_error};
        want = {v.exp_buf, v.la, v.lt, v.sa, v.snt, v.err};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got buf=%h la=%b lt=%b sa=%b snt=%b err=%b, expected buf=%h la=%b lt=%b sa=%b snt=%b err=%b",
                     v.name, n_vec, got[20:5], got[4], got[3], got[2], got[1], got[0],
                     v.exp_buf, v.la, v.lt, v.sa, v.snt, v.err);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [3:0] k,
                        input logic a, input logic t, input logic o, input logic [15:0] b,
                        input logic la, input logic lt, input logic sa, input logic snt,
                        input logic err);
        vec_t v;
        v.name = name; v.rst = r; v.key = k; v.abtn = a; v.tbtn = t; v.tick = o;
        v.exp_buf = b; v.la = la; v.lt = lt; v.sa = sa; v.snt = snt; v.err = err;
        apply(v);
    endtask

    task automatic press_now(input string name, input logic [3:0] d,
                             input logic [15:0] b0, input logic [15:0] b1);
        step(name, 1'b1, d,  1'b0, 1'b0, 1'b0, b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(name, 1'b1, NK, 1'b0, 1'b0, 1'b0, b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(name, 1'b1, NK, 1'b0, 1'b0, 1'b0, b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Nine ticks (each followed by a quiet cycle) that must not end the entry.
    task automatic nine_ticks(input string name, input logic [15:0] b);
        for (int i = 0; i < 9; i++) begin
            step(name, 1'b1, NK, 1'b0, 1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(name, 1'b1, NK, 1'b0, 1'b0, 1'b0, b, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; key = NK; alarm_button = 1'b0; time_button = 1'b0; one_second = 1'b0;

        // Reset and release
        add("reset", 1'b0, NK, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add("reset", 1'b0, NK, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_idle("post_reset");

        // 1234 committed to alarm
        add_digit("k1234_d1", 4'd1, 16'h0000, 16'h0001);
        add_digit("k1234_d2", 4'd2, 16'h0001, 16'h0012);
        add_digit("k1234_d3", 4'd3, 16'h0012, 16'h0123);
        add_digit("k1234_d4", 4'd4, 16'h0123, 16'h1234);
        add("commit_alarm_1234", 1'b1, NK, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add_idle("clear_after_1234");

        // 2500 rejected (hours 25)
        add_digit("k2500", 4'd2, 16'h0000, 16'h0002);
        add_digit("k2500", 4'd5, 16'h0002, 16'h0025);
        add_digit("k2500", 4'd0, 16'h0025, 16'h0250);
        add_digit("k2500", 4'd0, 16'h0250, 16'h2500);
        add("commit_time_2500", 1'b1, NK, 1'b0, 1'b1, 1'b0, 16'h2500, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        add_idle("clear_after_2500");

        // 2359 accepted for time
        add_digit("k2359", 4'd2, 16'h0000, 16'h0002);
        add_digit("k2359", 4'd3, 16'h0002, 16'h0023);
        add_digit("k2359", 4'd5, 16'h0023, 16'h0235);
        add_digit("k2359", 4'd9, 16'h0235, 16'h2359);
        add("commit_time_2359", 1'b1, NK, 1'b0, 1'b1, 1'b0, 16'h2359, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add_idle("clear_after_2359");

        // 1260 rejected (minutes tens 6)
        add_digit("k1260", 4'd1, 16'h0000, 16'h0001);
        add_digit("k1260", 4'd2, 16'h0001, 16'h0012);
        add_digit("k1260", 4'd6, 16'h0012, 16'h0126);
        add_digit("k1260", 4'd0, 16'h0126, 16'h1260);
        add("commit_time_1260", 1'b1, NK, 1'b0, 1'b1, 1'b0, 16'h1260, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        add_idle("clear_after_1260");

        // Only two digits: rejected
        add_digit("k07", 4'd0, 16'h0000, 16'h0000);
        add_digit("k07", 4'd7, 16'h0000, 16'h0007);
        add("commit_short_07", 1'b1, NK, 1'b0, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        add_idle("clear_after_07");

        // Five digits: oldest shifts out, count saturates at 4
        add_digit("k91234", 4'd9, 16'h0000, 16'h0009);
        add_digit("k91234", 4'd1, 16'h0009, 16'h0091);
        add_digit("k91234", 4'd2, 16'h0091, 16'h0912);
        add_digit("k91234", 4'd3, 16'h0912, 16'h9123);
        add_digit("k91234", 4'd4, 16'h9123, 16'h1234);
        add("commit_alarm_91234", 1'b1, NK, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add_idle("clear_after_91234");

        // Both buttons together: alarm wins
        add_digit("k0815", 4'd0, 16'h0000, 16'h0000);
        add_digit("k0815", 4'd8, 16'h0000, 16'h0008);
        add_digit("k0815", 4'd1, 16'h0008, 16'h0081);
        add_digit("k0815", 4'd5, 16'h0081, 16'h0815);
        add("both_buttons_0815", 1'b1, NK, 1'b1, 1'b1, 1'b0, 16'h0815, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add_idle("clear_after_0815");

        // Alarm button held 5 cycles in IDLE; a key during the hold is ignored
        add("show_alarm", 1'b1, NK,   1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add("show_alarm", 1'b1, NK,   1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add("show_alarm", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add("show_alarm", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add("show_alarm", 1'b1, NK,   1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_idle("show_alarm_release");
        add_idle("show_alarm_idle");

        // Reset mid-entry, then time_button in IDLE does nothing
        add_digit("k42", 4'd4, 16'h0000, 16'h0004);
        add_digit("k42", 4'd2, 16'h0004, 16'h0042);
        add("reset_mid_entry", 1'b0, NK, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_idle("after_mid_reset");
        add("idle_time_button", 1'b1, NK, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_idle("idle_after_time_button");

        foreach (table_q[i]) apply(table_q[i]);

        // Timeout: nine ticks keep the entry, a press restarts the count, the tenth abandons
        press_now("to_key1", 4'd1, 16'h0000, 16'h0001);
        nine_ticks("to_nine_a", 16'h0001);
        press_now("to_key2", 4'd2, 16'h0001, 16'h0012);
        nine_ticks("to_nine_b", 16'h0012);
        step("to_tenth", 1'b1, NK, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("to_after", 1'b1, NK, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Press coinciding with the final tick wins and restarts the count
        press_now("pw_key5", 4'd5, 16'h0000, 16'h0005);
        nine_ticks("pw_nine", 16'h0005);
        step("pw_press_on_tick", 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pw_shift",         1'b1, NK,   1'b0, 1'b0, 1'b0, 16'h0056, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pw_entry",         1'b1, NK,   1'b0, 1'b0, 1'b0, 16'h0056, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pw_tick_after",    1'b1, NK,   1'b0, 1'b0, 1'b1, 16'h0056, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("pw_reset",         1'b0, NK,   1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pw_release",       1'b1, NK,   1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Key 3 held for 20 cycles yields exactly one shift
        step("held_first", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++)
            step("held_key3", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("held_release", 1'b1, NK, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("held_entry",   1'b1, NK, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("held_commit",  1'b1, NK, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("held_clear",   1'b1, NK, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
Sequencer for the clock's keypad datapath. It captures keypad digits into a 4-digit entry buffer and validates the buffer as HH:MM. It then issues a one-cycle load strobe to the alarm register (alarm_button) or the time counter (time_button). It also drives the display-select flags that the alarm_clock display mux consumes, and sits between the raw key/button inputs and the time/alarm registers.

Parameters:
NOKEY, 4'd10, key code meaning "no key pressed"; codes 0-9 are digits, 11-15 are ignored like NOKEY.
TIMEOUT, 10, number of one_second pulses without a new key press before an entry is abandoned.

Ports:
clk  in  1  system clock, 256 Hz in the product; logic is rate-agnostic.
reset  in  1  synchronous, active-low reset; sampled on rising clk.
key  in  4  keypad code, level, held for the duration of the press.
alarm_button  in  1  active-high; commit buffer to alarm, or show alarm when idle.
time_button  in  1  active-high; commit buffer to current time.
one_second  in  1  single-cycle tick, once per second.
key_buffer_ms_hr  out  4  entry digit: hours tens.
key_buffer_ls_hr  out  4  entry digit: hours units.
key_buffer_ms_min  out  4  entry digit: minutes tens.
key_buffer_ls_min  out  4  entry digit: minutes units.
load_alarm  out  1  one-cycle strobe; alarm register captures the buffer.
load_new_time  out  1  one-cycle strobe; time counter captures the buffer.
show_alarm  out  1  display the alarm time.
show_new_time  out  1  display the entry buffer.
entry_error  out  1  one-cycle pulse; rejected commit.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, all buffer digits=0, digit_count=0, timeout count=0, key_prev=NOKEY.
  - All 1-bit outputs=0; this holds even when reset is asserted mid-entry or mid-COMMIT.
- key_prev register: updated every cycle to key, with codes >9 normalised to NOKEY.
- Press detection: a new press is key<=9 while key_prev==NOKEY. A held key yields exactly one press. Changing directly from one digit to another without passing through NOKEY is not a press.
- States and transitions:
  - IDLE:
    - new press -> KEY_STORED, latching the digit.
    - else alarm_button==1 -> SHOW_ALARM.
    - time_button is ignored.
  - SHOW_ALARM: show_alarm=1; returns to IDLE on the first cycle alarm_button==0. Key presses are ignored.
  - KEY_STORED (1 cycle):
    - Buffer shifts left: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=digit.
    - digit_count increments, saturating at 4; timeout count clears.
    - Next state KEY_WAIT.
  - KEY_WAIT: stays until key is NOKEY (or >9), then -> KEY_ENTRY.
  - KEY_ENTRY, priority order:
    - new press -> KEY_STORED.
    - alarm_button -> COMMIT targeting alarm; alarm wins if both buttons are high.
    - time_button -> COMMIT targeting time.
    - buttons are not acted on in KEY_STORED or KEY_WAIT.
  - COMMIT (1 cycle), then IDLE with buffer, digit_count and timeout count cleared:
    - Valid means digit_count==4, hours (ms_hr*10+ls_hr) <=23, ms_min<=5, and ls_min<=9 (always true).
    - If valid, assert the targeted strobe; otherwise entry_error=1.
    - The buffer is unchanged during COMMIT, so the datapath samples it alongside the strobe.
- show_new_time=1 in KEY_STORED, KEY_WAIT, KEY_ENTRY and COMMIT.
- Latency:
  - A digit sampled at edge E0 appears in key_buffer_ls_min after edge E1.
  - A button sampled at edge En in KEY_ENTRY produces the strobe or error during the cycle after En, and the buffer reads 0 after En+1.
- Timeout: in KEY_STORED/KEY_WAIT/KEY_ENTRY, each one_second pulse increments the count. On reaching TIMEOUT the block goes to IDLE and clears everything, with no error and no strobe. A press in the same cycle as the final tick wins, and the count clears.
- All outputs are Moore, decoded from registered state. The strobes and entry_error are never high for more than one cycle.

Test Plan:
1. Hold reset=0 for 2 cycles with key=NOKEY -> all outputs 0; after release, show_new_time=0 and buffer=0000.
2. Keys 1,2,3,4, each followed by NOKEY, then alarm_button for 1 cycle -> buffer 1,2,3,4; load_alarm high exactly 1 cycle with buffer=1234 in that cycle; buffer 0000 next cycle; load_new_time stays 0.
3. Keys 2,5,0,0 then time_button -> entry_error high 1 cycle, no strobe, buffer cleared. Keys 2,3,5,9 then time_button -> load_new_time high 1 cycle. Keys 1,2,6,0 -> entry_error.
4. Keys 0,7 only, then time_button -> entry_error, buffer 0000. Five keys 9,1,2,3,4 with alarm_button -> buffer 1234 and load_alarm asserted.
5. Key 1, then 9 one_second pulses -> still KEY_ENTRY with show_new_time=1. Key 2 followed by 9 more pulses -> still entry. A 10th pulse -> IDLE, buffer 0000, no error, no strobe.
6. Key 3 held 20 cycles -> exactly one shift. alarm_button held 5 cycles in IDLE -> show_alarm=1 for 5 cycles, no strobe. Both buttons high together in KEY_ENTRY with valid 0815 -> load_alarm only. reset=0 during KEY_ENTRY -> buffer 0000 at the next edge.
